// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
// Holds the arbiter state encoding, frame geometry and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    StArb      = 2'd0,
    StWaitByte = 2'd1,
    StSend     = 2'd2
  } arb_state_e;

  // Start bit + 8 data bits + stop bit.
  localparam int unsigned FrameBits = 10;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: shifts one byte out LSB-first, each bit held for DIV clock cycles.
// o_done fires one cycle before the stop bit ends so a follow-on byte starts with no gap.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_txd,
  output logic       o_done
);

  localparam int unsigned CntW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(DIV - 1);
  localparam logic [CntW-1:0] BaudDone = CntW'(DIV - 2);
  localparam logic [3:0]      BitStop  = 4'(FrameBits - 1);

  logic            r_active;
  logic [7:0]      r_shift;
  logic [3:0]      r_bit_cnt;
  logic [CntW-1:0] r_baud_cnt;
  logic            r_txd;

  logic            w_active_d;
  logic [7:0]      w_shift_d;
  logic [3:0]      w_bit_cnt_d;
  logic [CntW-1:0] w_baud_cnt_d;
  logic            w_txd_d;

  always_comb begin
    w_active_d   = r_active;
    w_shift_d    = r_shift;
    w_bit_cnt_d  = r_bit_cnt;
    w_baud_cnt_d = r_baud_cnt;
    w_txd_d      = r_txd;
    if (i_start) begin
      w_active_d   = 1'b1;
      w_shift_d    = i_data;
      w_bit_cnt_d  = '0;
      w_baud_cnt_d = '0;
      w_txd_d      = 1'b0;
    end else if (r_active) begin
      if (r_baud_cnt == BaudLast) begin
        w_baud_cnt_d = '0;
        if (r_bit_cnt == BitStop) begin
          w_active_d = 1'b0;
        end else begin
          w_bit_cnt_d = r_bit_cnt + 4'd1;
          // Bit k of the frame ending means data bit k goes out next; after bit 8, the stop bit.
          w_txd_d     = (r_bit_cnt < 4'd8) ? r_shift[r_bit_cnt[2:0]] : 1'b1;
        end
      end else begin
        w_baud_cnt_d = r_baud_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active   <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_active   <= w_active_d;
      r_shift    <= w_shift_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_baud_cnt <= w_baud_cnt_d;
      r_txd      <= w_txd_d;
    end
  end

  always_comb begin
    o_txd  = r_txd;
    o_done = r_active && (r_bit_cnt == BitStop) && (r_baud_cnt == BaudDone);
  end

  // A new byte may only arrive when idle or exactly in the last cycle of the stop bit.
  a_start_aligned: assert property (@(posedge clk) disable iff (reset)
    i_start |-> (!r_active || (r_bit_cnt == BitStop && r_baud_cnt == BaudLast)));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one 8N1 TXD line between N byte-stream requesters.
// A grant is held from the first byte until the owner's last byte or an idle timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned TIMEOUT = 65536
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           timeout_err,
  output logic           txd
);

  localparam int unsigned Div   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned PtrW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(N - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

  arb_state_e       r_state, w_state_d;
  logic [N-1:0]     r_grant, w_grant_d;
  logic [PtrW-1:0]  r_owner, w_owner_d;
  logic [PtrW-1:0]  r_rr_ptr, w_rr_ptr_d;
  logic [IdleW-1:0] r_idle_cnt, w_idle_cnt_d;
  logic             r_last, w_last_d;
  logic             r_timeout_err, w_timeout_err_d;

  logic             w_any_valid;
  logic [PtrW-1:0]  w_pick;
  logic [N-1:0]     w_pick_oh;
  int unsigned      w_idx;
  logic [PtrW-1:0]  w_owner_inc;
  logic             w_accept;
  logic [7:0]       w_byte;
  logic             w_done;

  // First valid requester at or after the round-robin pointer, wrapping cyclically.
  always_comb begin
    w_any_valid = 1'b0;
    w_pick      = '0;
    w_pick_oh   = '0;
    w_idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = 32'(r_rr_ptr) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      if (!w_any_valid && req_valid[PtrW'(w_idx)]) begin
        w_any_valid                = 1'b1;
        w_pick                     = PtrW'(w_idx);
        w_pick_oh[PtrW'(w_idx)]    = 1'b1;
      end
    end
  end

  always_comb begin
    w_owner_inc = (r_owner == PtrLast) ? '0 : r_owner + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StArb;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic, including the grant, pointer and idle-timeout bookkeeping.
  always_comb begin
    w_state_d       = r_state;
    w_grant_d       = r_grant;
    w_owner_d       = r_owner;
    w_rr_ptr_d      = r_rr_ptr;
    w_idle_cnt_d    = r_idle_cnt;
    w_last_d        = r_last;
    w_timeout_err_d = 1'b0;
    case (r_state)
      StArb: begin
        if (w_any_valid) begin
          w_state_d    = StWaitByte;
          w_grant_d    = w_pick_oh;
          w_owner_d    = w_pick;
          w_idle_cnt_d = '0;
        end
      end
      StWaitByte: begin
        if (w_accept) begin
          w_last_d  = req_last[r_owner];
          w_state_d = StSend;
        end else if (r_idle_cnt == IdleLast) begin
          w_state_d       = StArb;
          w_grant_d       = '0;
          w_rr_ptr_d      = w_owner_inc;
          w_timeout_err_d = 1'b1;
        end else begin
          w_idle_cnt_d = r_idle_cnt + 1'b1;
        end
      end
      StSend: begin
        if (w_done) begin
          if (r_last) begin
            w_state_d  = StArb;
            w_grant_d  = '0;
            w_rr_ptr_d = w_owner_inc;
          end else begin
            w_state_d    = StWaitByte;
            w_idle_cnt_d = '0;
          end
        end
      end
      default: begin
        w_state_d = StArb;
        w_grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant       <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_idle_cnt    <= '0;
      r_last        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_grant       <= w_grant_d;
      r_owner       <= w_owner_d;
      r_rr_ptr      <= w_rr_ptr_d;
      r_idle_cnt    <= w_idle_cnt_d;
      r_last        <= w_last_d;
      r_timeout_err <= w_timeout_err_d;
    end
  end

  // Outputs.
  always_comb begin
    req_ready   = (r_state == StWaitByte) ? r_grant : '0;
    grant       = r_grant;
    busy        = (r_state != StArb);
    timeout_err = r_timeout_err;
    w_accept    = (r_state == StWaitByte) && req_valid[r_owner];
    w_byte      = req_data[{r_owner, 3'b000} +: 8];
  end

  uart_tx_serializer #(
    .DIV (Div)
  ) u_serializer (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept),
    .i_data  (w_byte),
    .o_txd   (txd),
    .o_done  (w_done)
  );

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(r_grant));
  a_ready_owner: assert property (@(posedge clk) disable iff (reset)
    (req_ready & ~r_grant) == '0);
  a_arb_no_grant: assert property (@(posedge clk) disable iff (reset)
    (r_state == StArb) |-> (r_grant == '0));
  a_timeout_in_arb: assert property (@(posedge clk) disable iff (reset)
    r_timeout_err |-> (r_state == StArb));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: framing, packet-level round robin, timeout and reset.
module tb_uart_tx_arbiter;

  localparam int N   = 2;
  localparam int DIV = 434;
  localparam int TMO = 100;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_err;
  logic           txd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx_arbiter #(
    .N       (N),
    .CLK_HZ  (50000000),
    .BAUD    (115200),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .txd         (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    reset     = 1'b1;
    step();
    step();
    #2 reset = 1'b0;
    step();
  endtask

  // Waits for a start bit, then samples every bit at its centre.
  task automatic capture(output logic [7:0] b, output logic stop_ok, output logic start_ok,
                         output int t_start);
    int budget;
    b = '0; stop_ok = 1'b0; start_ok = 1'b0; t_start = -1; budget = 0;
    while (txd !== 1'b0 && budget < 30 * DIV) begin
      step();
      budget++;
    end
    if (txd !== 1'b0) return;
    t_start = cyc;
    repeat (DIV / 2) step();
    start_ok = (txd === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) step();
      b[i] = txd;
    end
    repeat (DIV) step();
    stop_ok = (txd === 1'b1);
  endtask

  // Presents n bytes as one packet on requester r, honouring ready.
  task automatic producer(input int r, input logic [31:0] bytes, input int n, output logic ok);
    int budget;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      req_data[8*r +: 8] = bytes[8*k +: 8];
      req_last[r]        = (k == n - 1);
      req_valid[r]       = 1'b1;
      budget             = 0;
      while (req_ready[r] !== 1'b1 && budget < 40 * DIV) begin
        step();
        budget++;
      end
      if (req_ready[r] !== 1'b1) begin
        ok           = 1'b0;
        req_valid[r] = 1'b0;
        return;
      end
      step();
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '0; req_last = '0; req_data = '0;
    reset = 1'b1;
    step();
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %b want 0", timeout_err); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
    #2 reset = 1'b0;
    repeat (6) step();
    checks++;
    if ({busy, txd, grant} !== 4'b0100) begin
      errors++; $display("FAIL idle_after_reset got busy/txd/grant %b want 0100", {busy, txd, grant});
    end
  endtask

  task automatic test_single_byte();
    int t0, ts;
    logic [7:0] b;
    logic sok, stk;
    do_reset();
    t0 = cyc;
    req_data[7:0] = 8'hA5; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", grant); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
    step();
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    capture(b, sok, stk, ts);
    checks++; if (ts !== t0 + 2) begin errors++; $display("FAIL single_start got %0d want %0d", ts - t0, 2); end
    checks++; if (b !== 8'hA5 || stk !== 1'b1) begin errors++; $display("FAIL single_byte got %h/%b want a5/1", b, stk); end
    checks++; if (sok !== 1'b1) begin errors++; $display("FAIL single_stop got %b want 1", sok); end
    while (cyc < t0 + 10 * DIV) step();
    checks++; if (grant !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL single_hold got %b/%b want 01/1", grant, busy); end
    step();
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || txd !== 1'b1) begin
      errors++; $display("FAIL single_release got grant %b busy %b txd %b want 00 0 1", grant, busy, txd);
    end
  endtask

  task automatic test_packets();
    logic [7:0] got [6];
    logic [7:0] exp_b [6];
    logic sok [6];
    logic stk [6];
    int ts [6];
    int exp_gap [5];
    logic ok0, ok1;
    exp_b   = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
    exp_gap = '{10 * DIV, 10 * DIV, 10 * DIV + 1, 10 * DIV, 10 * DIV};
    do_reset();
    fork
      producer(0, 32'h00131211, 3, ok0);
      producer(1, 32'h00232221, 3, ok1);
      for (int i = 0; i < 6; i++) capture(got[i], sok[i], stk[i], ts[i]);
    join
    checks++; if ({ok0, ok1} !== 2'b11) begin errors++; $display("FAIL packets_accept got %b want 11", {ok0, ok1}); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== exp_b[i] || sok[i] !== 1'b1) begin
        errors++; $display("FAIL packets_byte%0d got %h/%b want %h/1", i, got[i], sok[i], exp_b[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ts[i+1] - ts[i] !== exp_gap[i]) begin
        errors++; $display("FAIL packets_gap%0d got %0d want %0d", i, ts[i+1] - ts[i], exp_gap[i]);
      end
    end
  endtask

  task automatic test_alternation();
    logic [7:0] got [4];
    logic [7:0] exp_b [4];
    logic sok [4];
    logic stk [4];
    int ts [4];
    logic a, b, c, d;
    exp_b = '{8'h31, 8'h40, 8'h33, 8'h42};
    do_reset();
    fork
      begin
        producer(1, 32'h31, 1, a);
        producer(1, 32'h33, 1, b);
      end
      begin
        repeat (10) step();
        producer(0, 32'h40, 1, c);
        producer(0, 32'h42, 1, d);
      end
      for (int i = 0; i < 4; i++) capture(got[i], sok[i], stk[i], ts[i]);
    join
    checks++; if ({a, b, c, d} !== 4'b1111) begin errors++; $display("FAIL alt_accept got %b want 1111", {a, b, c, d}); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin
        errors++; $display("FAIL alt_order%0d got %h want %h", i, got[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int ts, ts2, pulses, pulse_cyc, txd_low;
    logic [7:0] b;
    logic sok, stk;
    do_reset();
    req_data = 16'h6655; req_last = 2'b10; req_valid = 2'b11;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tmo_first_grant got %b want 01", grant); end
    step();
    req_valid[0] = 1'b0;
    capture(b, sok, stk, ts);
    checks++; if (b !== 8'h55) begin errors++; $display("FAIL tmo_first_byte got %h want 55", b); end
    pulses = 0; pulse_cyc = -1; txd_low = 0;
    while (cyc < ts + 10 * DIV + TMO) begin
      step();
      if (timeout_err === 1'b1) begin pulses++; pulse_cyc = cyc; end
      if (txd !== 1'b1) txd_low++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL tmo_pulse_count got %0d want 1", pulses); end
    checks++;
    if (pulse_cyc !== ts + 10 * DIV + TMO - 1) begin
      errors++; $display("FAIL tmo_pulse_time got %0d want %0d", pulse_cyc - ts, 10 * DIV + TMO - 1);
    end
    checks++; if (txd_low !== 0) begin errors++; $display("FAIL tmo_txd_idle got %0d low cycles want 0", txd_low); end
    checks++; if (grant !== 2'b10 || req_ready !== 2'b10) begin errors++; $display("FAIL tmo_handover got %b/%b want 10/10", grant, req_ready); end
    step();
    req_valid[1] = 1'b0;
    capture(b, sok, stk, ts2);
    checks++; if (ts2 !== ts + 10 * DIV + TMO + 1) begin errors++; $display("FAIL tmo_second_start got %0d want %0d", ts2 - ts, 10 * DIV + TMO + 1); end
    checks++; if (b !== 8'h66 || sok !== 1'b1) begin errors++; $display("FAIL tmo_second_byte got %h/%b want 66/1", b, sok); end
  endtask

  task automatic test_reset_mid_frame();
    int t0, t1, ts;
    logic [7:0] b;
    logic sok, stk;
    do_reset();
    t0 = cyc;
    req_data[7:0] = 8'hC3; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    while (cyc < t0 + 2 + 4 * DIV + 10) step();
    checks++; if (txd !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL mid_before got txd %b grant %b want 0 01", txd, grant); end
    #2 reset = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL mid_txd got %b want 1", txd); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mid_grant got %b want 00", grant); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_ready got %b want 00", req_ready); end
    step();
    #2 reset = 1'b0;
    t1 = cyc;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL mid_regrant got %b want 01", grant); end
    step();
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    capture(b, sok, stk, ts);
    checks++; if (ts !== t1 + 2) begin errors++; $display("FAIL mid_restart got %0d want 2", ts - t1); end
    checks++; if (b !== 8'hC3 || sok !== 1'b1) begin errors++; $display("FAIL mid_byte got %h/%b want c3/1", b, sok); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    logic s0, s1, k0, k1, ok;
    int ts0, ts1;
    do_reset();
    fork
      producer(0, 32'h0000FF00, 2, ok);
      begin
        capture(b0, s0, k0, ts0);
        capture(b1, s1, k1, ts1);
      end
    join
    checks++; if (b0 !== 8'h00 || s0 !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b want 00/1", b0, s0); end
    checks++; if (b1 !== 8'hFF || s1 !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b want ff/1", b1, s1); end
    checks++; if (ts1 - ts0 !== 10 * DIV) begin errors++; $display("FAIL b2b_gap got %0d want %0d", ts1 - ts0, 10 * DIV); end
    while (cyc < ts0 + 20 * DIV - 2) step();
    checks++; if (busy !== 1'b1 || txd !== 1'b1) begin errors++; $display("FAIL b2b_tail got busy %b txd %b want 1 1", busy, txd); end
    step();
    checks++; if (busy !== 1'b0 || txd !== 1'b1) begin errors++; $display("FAIL b2b_end got busy %b txd %b want 0 1", busy, txd); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_packets();
    test_alternation();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
